multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore/Mealy FSM that sequences a multi-cycle RV32I datapath built around the shared ALU, ALU_control decoder, register file and a single unified memory.
- Decodes the opcode held in the instruction register and drives the mux selects, write enables and the 2-bit aluop consumed by ALU_control (00 add, 01 subtract, 10 use funct).
- Handles memory wait states and timeouts.
- Supports R-type, I-type ALU, lw, sw, beq and jal; any other opcode is illegal.

Parameters:
- MEM_TIMEOUT, 16: maximum number of cycles to wait for mem_ready in any memory state. 0 disables the timeout.
- TO_W, 5: width of the timeout counter. Must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  instr[6:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  store strobe; valid only while mem_req=1.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU output register.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  load the PC.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  2  ALU A select: 00 PC, 01 oldPC, 10 rs1.
- alu_src_b  out  2  ALU B select: 00 rs2, 01 imm, 10 constant 4.
- result_src  out  2  result select: 00 ALU output register, 01 memory data register, 10 ALU result.
- aluop  out  2  to ALU_control.
- illegal  out  1  sticky fault flag.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset:
  - While reset=1, every output is 0 and the next state is FETCH.
  - Reset asserted mid-instruction aborts it immediately; no write strobe is issued in the reset cycle.
- Outputs are a combinational decode of state; the Mealy terms are noted below. Any output not listed for a state is 0.
- Timeout counter:
  - Clears on entry to FETCH, MEMREAD and MEMWRITE.
  - Increments each cycle in those states while mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0, the FSM goes to ERROR.
- States and transitions:
  - FETCH:
    - Outputs: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, aluop=00, result_src=10.
    - ir_write = pc_write = mem_ready (Mealy).
    - Stays in FETCH until mem_ready, then goes to DECODE.
  - DECODE:
    - Outputs: alu_src_a=01, alu_src_b=01, aluop=00 (branch/jump target precompute).
    - Next state by opcode: 0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011 or 0100011 -> MEMADR; 1100011 -> BEQ; 1101111 -> JAL; otherwise ERROR.
  - MEMADR:
    - Outputs: alu_src_a=10, alu_src_b=01, aluop=00.
    - Goes to MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD:
    - Outputs: mem_req=1, adr_src=1.
    - Waits for mem_ready, then goes to MEMWB.
  - MEMWB:
    - Outputs: reg_write=1, result_src=01.
    - Goes to FETCH.
  - MEMWRITE:
    - Outputs: mem_req=1, mem_write=1, adr_src=1.
    - Waits for mem_ready, then goes to FETCH.
  - EXEC_R:
    - Outputs: alu_src_a=10, alu_src_b=00, aluop=10.
    - Goes to ALUWB.
  - EXEC_I:
    - Outputs: alu_src_a=10, alu_src_b=01, aluop=10.
    - Goes to ALUWB.
  - ALUWB:
    - Outputs: reg_write=1, result_src=00.
    - Goes to FETCH.
  - BEQ:
    - Outputs: alu_src_a=10, alu_src_b=00, aluop=01, result_src=00.
    - pc_write = zero (Mealy).
    - Goes to FETCH.
  - JAL:
    - Outputs: alu_src_a=01, alu_src_b=10, aluop=00, result_src=00, pc_write=1.
    - Goes to ALUWB.
  - ERROR:
    - Outputs: illegal=1; all strobes 0.
    - Only reset exits ERROR.
- Cycle counts with zero-wait memory: R/I-type 4, lw 5, sw 4, beq 3, jal 4. Each mem_ready=0 cycle adds one cycle.
- Strobe rules:
  - pc_write and reg_write are never both asserted in the same cycle.
  - mem_write is never asserted outside MEMWRITE.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BEQ=9, JAL=10, ERROR=15. Unused codes go to ERROR.

Optional Feature:
- Macro MC_CTRL_PERF_EN. When defined, two extra outputs are added:
  - cycle_cnt (32 bits): increments every non-reset cycle.
  - instret_cnt (32 bits): increments on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
- Both counters reset to 0, wrap modulo 2^32, and freeze in ERROR.
- When the macro is undefined, the ports and logic are absent.

Test Plan:
- reset held 3 cycles, then released with mem_ready=1 -> all outputs 0 during reset; FETCH, cycle after release, shows mem_req=1 and ir_write=pc_write=1; state_dbg=0.
- opcode=0110011, mem_ready=1 -> state_dbg sequence 0,1,6,8,0; aluop=10 in EXEC_R; reg_write=1 only in ALUWB.
- lw (0000011) with mem_ready low for 2 cycles in MEMREAD -> sequence 0,1,2,3,3,3,4,0; reg_write=1 with result_src=01 in MEMWB.
- beq (1100011), zero=1 then repeated with zero=0 -> pc_write=1 in BEQ only when zero=1; aluop=01; 3 cycles each.
- opcode=1111111 -> ERROR after DECODE, illegal=1 held for 10 cycles; reset clears it and returns to FETCH.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> ERROR entered after 4 wait cycles; with MC_CTRL_PERF_EN, instret_cnt=0 and both counters frozen in ERROR.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control FSM for a multi-cycle RV32I datapath, with memory wait states and a timeout watchdog.
// Optional performance counters are built only when MC_CTRL_PERF_EN is defined.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] aluop,
  output logic       illegal,
  output logic [3:0] state_dbg
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ERROR    = 4'd15
  } state_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [TO_W-1:0] to_inc;
  logic            wait_state;
  logic            timeout_hit;

  // State register and wait-cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // Counter is zero on entry to any memory state, so it counts wait cycles of the current access only
  assign wait_state  = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  assign to_inc      = to_cnt_q + 1'b1;
  assign timeout_hit = (MEM_TIMEOUT != 0) && wait_state && !mem_ready &&
                       (to_inc == TO_W'(MEM_TIMEOUT));
  assign to_cnt_d    = (wait_state && !mem_ready) ? to_inc : '0;

  // Next-state logic
  always_comb begin
    state_d = S_ERROR;
    case (state_q)
      S_FETCH: begin
        if (timeout_hit)    state_d = S_ERROR;
        else if (mem_ready) state_d = S_DECODE;
        else                state_d = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMREAD;
        else if (opcode == OP_SW) state_d = S_MEMWRITE;
        else                      state_d = S_ERROR;
      end
      S_MEMREAD: begin
        if (timeout_hit)    state_d = S_ERROR;
        else if (mem_ready) state_d = S_MEMWB;
        else                state_d = S_MEMREAD;
      end
      S_MEMWRITE: begin
        if (timeout_hit)    state_d = S_ERROR;
        else if (mem_ready) state_d = S_FETCH;
        else                state_d = S_MEMWRITE;
      end
      S_MEMWB:  state_d = S_FETCH;
      S_EXEC_R: state_d = S_ALUWB;
      S_EXEC_I: state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_JAL:    state_d = S_ALUWB;
      default:  state_d = S_ERROR;
    endcase
  end

  // Output decode; reset forces every output low, including in-flight write strobes
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    aluop      = 2'b00;
    illegal    = 1'b0;
    state_dbg  = 4'd0;
    if (!reset) begin
      state_dbg = state_q;
      case (state_q)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          result_src = 2'b01;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = 2'b10;
          aluop     = 2'b10;
        end
        S_EXEC_I: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          aluop     = 2'b10;
        end
        S_ALUWB: reg_write = 1'b1;
        S_BEQ: begin
          alu_src_a = 2'b10;
          aluop     = 2'b01;
          pc_write  = zero;
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] instret_q, instret_d;
  logic        retire;

  assign retire = (state_d == S_FETCH) &&
                  ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                   (state_q == S_ALUWB) || (state_q == S_BEQ));

  // Counters freeze once the controller has faulted
  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if (state_q != S_ERROR) begin
      cycle_d = cycle_q + 32'd1;
      if (retire) instret_d = instret_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt   = reset ? 32'd0 : cycle_q;
  assign instret_cnt = reset ? 32'd0 : instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl: expected state/outputs are queued per cycle and
// compared at the falling edge. Counter checks are compiled in when MC_CTRL_PERF_EN is defined.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src, aluop;
  logic [3:0] state_dbg;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(4), .TO_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .aluop      (aluop),
    .illegal    (illegal),
    .state_dbg  (state_dbg)
`ifdef MC_CTRL_PERF_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
`endif
  );

  typedef struct packed {
    logic [3:0]  st;
    logic [14:0] outs;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] m_cyc    = 0;
  logic [31:0] m_ret    = 0;

  // Expected outputs per state, packed as
  // {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, src_a, src_b, result_src, aluop, illegal}
  function automatic logic [14:0] exp_outs(input logic [3:0] st, input logic mr, input logic z);
    case (st)
      4'd0:    return {1'b1, 1'b0, 1'b0, mr, mr, 1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0};
      4'd1:    return {6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
      4'd2:    return {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
      4'd3:    return {6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      4'd4:    return {6'b000001, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0};
      4'd5:    return {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      4'd6:    return {6'b000000, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0};
      4'd7:    return {6'b000000, 2'b10, 2'b01, 2'b00, 2'b10, 1'b0};
      4'd8:    return {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      4'd9:    return {3'b000, 1'b0, z, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0};
      4'd10:   return {6'b000010, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0};
      default: return {6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
    endcase
  endfunction

  task automatic check_front();
    exp_t        e;
    logic [14:0] obs;
    n_assert++;
    assert (sb_q.size() != 0) else begin
      n_fail++;
      $error("FAIL sb_empty observed=0 expected=1 entry");
      return;
    end
    e   = sb_q.pop_front();
    obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, aluop, illegal};
    n_assert++;
    assert (state_dbg === e.st) else begin
      n_fail++;
      $error("FAIL state_dbg observed=%0d expected=%0d", state_dbg, e.st);
    end
    n_assert++;
    assert (obs === e.outs) else begin
      n_fail++;
      $error("FAIL outputs st=%0d observed=%b expected=%b", e.st, obs, e.outs);
    end
    n_assert++;
    assert (!(pc_write && reg_write)) else begin
      n_fail++;
      $error("FAIL pc_reg_excl observed=%b%b expected=not both", pc_write, reg_write);
    end
`ifdef MC_CTRL_PERF_EN
    n_assert++;
    assert (cycle_cnt === e.cyc) else begin
      n_fail++;
      $error("FAIL cycle_cnt observed=%0d expected=%0d", cycle_cnt, e.cyc);
    end
    n_assert++;
    assert (instret_cnt === e.ret) else begin
      n_fail++;
      $error("FAIL instret_cnt observed=%0d expected=%0d", instret_cnt, e.ret);
    end
`endif
  endtask

  // One clock cycle: drive inputs, queue the expectation, compare at negedge, advance model at posedge
  task automatic step(input logic rst, input logic mr, input logic z, input logic [3:0] st);
    exp_t e;
    reset     = rst;
    mem_ready = mr;
    zero      = z;
    e.st   = rst ? 4'd0 : st;
    e.outs = rst ? 15'd0 : exp_outs(st, mr, z);
    e.cyc  = rst ? 32'd0 : m_cyc;
    e.ret  = rst ? 32'd0 : m_ret;
    sb_q.push_back(e);
    @(negedge clk);
    check_front();
    $display("cycle rst=%0b op=%b mr=%0b z=%0b state=%0d exp_state=%0d", rst, opcode, mr, z,
             state_dbg, e.st);
    @(posedge clk);
    if (rst) begin
      m_cyc = 0;
      m_ret = 0;
    end else if (st != 4'd15) begin
      m_cyc++;
      if (st == 4'd4 || st == 4'd8 || st == 4'd9 || (st == 4'd5 && mr)) m_ret++;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = 7'b0110011;

    // Reset held 3 cycles with memory ready
    repeat (3) step(1, 1, 0, 0);

    // R-type: 0,1,6,8
    opcode = 7'b0110011;
    step(0, 1, 0, 0); step(0, 1, 0, 1); step(0, 1, 0, 6); step(0, 1, 0, 8);
    // I-type: 0,1,7,8
    opcode = 7'b0010011;
    step(0, 1, 0, 0); step(0, 1, 0, 1); step(0, 1, 0, 7); step(0, 1, 0, 8);
    // lw with 2 wait cycles in MEMREAD: 0,1,2,3,3,3,4
    opcode = 7'b0000011;
    step(0, 1, 0, 0); step(0, 1, 0, 1); step(0, 1, 0, 2);
    step(0, 0, 0, 3); step(0, 0, 0, 3); step(0, 1, 0, 3); step(0, 1, 0, 4);
    // sw with 3 wait cycles: one short of the timeout
    opcode = 7'b0100011;
    step(0, 1, 0, 0); step(0, 1, 0, 1); step(0, 1, 0, 2);
    step(0, 0, 0, 5); step(0, 0, 0, 5); step(0, 0, 0, 5); step(0, 1, 0, 5);
    // beq taken then not taken
    opcode = 7'b1100011;
    step(0, 1, 1, 0); step(0, 1, 1, 1); step(0, 1, 1, 9);
    step(0, 1, 0, 0); step(0, 1, 0, 1); step(0, 1, 0, 9);
    // jal: 0,1,10,8 with a fetch wait cycle first
    opcode = 7'b1101111;
    step(0, 0, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 1); step(0, 1, 0, 10); step(0, 1, 0, 8);
    // sw aborted by reset while in MEMWRITE: no store strobe in the reset cycle
    opcode = 7'b0100011;
    step(0, 1, 0, 0); step(0, 1, 0, 1); step(0, 1, 0, 2); step(0, 0, 0, 5);
    step(1, 1, 0, 5);
    // Illegal opcode: ERROR held for 10 cycles, then reset returns to FETCH
    opcode = 7'b1111111;
    step(0, 1, 0, 0); step(0, 1, 0, 1);
    repeat (10) step(0, 1, 0, 15);
    step(1, 1, 0, 15);
    // Fetch timeout: 4 wait cycles then ERROR with counters frozen
    opcode = 7'b0110011;
    repeat (4) step(0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 15);
    step(0, 1, 0, 15);
    // Recovery after reset
    step(1, 1, 0, 15);
    step(0, 1, 0, 0); step(0, 1, 0, 1); step(0, 1, 0, 6); step(0, 1, 0, 8); step(0, 1, 0, 0);

    n_assert++;
    assert (sb_q.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain observed=%0d expected=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
